// File: rtl/spi_stream_arbiter.sv
// Round-robin, frame-granular arbiter sharing one spi_master byte stream among N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add the stalled-owner timeout that forces a grant release.
module spi_stream_arbiter #(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [N_REQ-1:0]   req_dc,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               spi_dc,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 65535 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("spi_stream_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;
  logic               spi_dc_q, spi_dc_d;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   owner_next;
  logic               frame_end;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    pick_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) pick_idx = PTR_W'(j);
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (PTR_W'(j) >= rr_ptr_q)) pick_idx = PTR_W'(j);
    end
  end

  assign owner_next = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Gated by rst_n so nothing is handed over during the reset cycle itself.
  always_comb begin
    req_ready = '0;
    m_data    = '0;
    m_valid   = 1'b0;
    if (rst_n && state_q == ST_GRANT) begin
      m_data    = req_data[{owner_q, 3'b000} +: 8];
      m_valid   = req_valid[owner_q];
      req_ready = grant_q & {N_REQ{m_ready}};
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    gap_cnt_d = gap_cnt_q;
    spi_dc_d  = spi_dc_q;
    frame_end = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SPI_ARB_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        if (|req_valid) begin
          owner_d = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req_valid[owner_q] && m_ready) begin
          spi_dc_d  = req_dc[owner_q];
          frame_end = req_last[owner_q];
        end
`ifdef SPI_ARB_TIMEOUT_EN
        if (req_valid[owner_q]) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          frame_end = 1'b1;
          timeout_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
`endif
        if (frame_end) begin
          grant_d  = '0;
          rr_ptr_d = owner_next;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = 16'(GAP_CYCLES - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates, so every register sees pre-edge values of the others.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      gap_cnt_q <= '0;
      spi_dc_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      gap_cnt_q <= gap_cnt_d;
      spi_dc_q  <= spi_dc_d;
`ifdef SPI_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign grant  = grant_q;
  assign spi_dc = spi_dc_q;
  assign busy   = rst_n && (state_q != ST_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_stream_arbiter.sv
// Self-checking bench for spi_stream_arbiter: directed scenarios plus a cycle monitor
// comparing the DUT against a frame-level round-robin reference model.
module tb_spi_stream_arbiter;
  localparam int N   = 2;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_dc, req_ready, grant;
  logic [7:0]     m_data;
  logic           m_valid, m_ready, spi_dc, busy, timeout;

  logic [15:0]    z_req_data;
  logic [1:0]     z_req_valid, z_req_last, z_req_dc, z_req_ready, z_grant;
  logic [7:0]     z_m_data;
  logic           z_m_valid, z_m_ready, z_spi_dc, z_busy, z_timeout;

  spi_stream_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_dc(req_dc), .req_ready(req_ready), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .spi_dc(spi_dc), .grant(grant),
    .busy(busy), .timeout(timeout));

  spi_stream_arbiter #(.N_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_data(z_req_data), .req_valid(z_req_valid),
    .req_last(z_req_last), .req_dc(z_req_dc), .req_ready(z_req_ready), .m_data(z_m_data),
    .m_valid(z_m_valid), .m_ready(z_m_ready), .spi_dc(z_spi_dc), .grant(z_grant),
    .busy(z_busy), .timeout(z_timeout));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (frame-level round robin) ----------------
  int mdl_owner = -1;
  int mdl_gap   = 0;
  int mdl_ptr   = 0;
  int mdl_stall = 0;
  bit mdl_dc    = 1'b0;
  bit mdl_to    = 1'b0;

  function automatic int rr_pick(int ptr, logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_owner <= -1; mdl_gap <= 0; mdl_ptr <= 0; mdl_stall <= 0; mdl_dc <= 1'b0; mdl_to <= 1'b0;
    end else begin
      mdl_to <= 1'b0;
      if (mdl_owner >= 0) begin
        if (req_valid[mdl_owner]) begin
          mdl_stall <= 0;
          if (m_ready) begin
            mdl_dc <= req_dc[mdl_owner];
            if (req_last[mdl_owner]) begin
              mdl_owner <= -1; mdl_ptr <= (mdl_owner + 1) % N; mdl_gap <= GAP;
            end
          end
        end else begin
          mdl_stall <= mdl_stall + 1;
`ifdef SPI_ARB_TIMEOUT_EN
          if (mdl_stall + 1 == TO) begin
            mdl_to <= 1'b1; mdl_owner <= -1; mdl_ptr <= (mdl_owner + 1) % N; mdl_gap <= GAP;
          end
`endif
        end
      end else if (mdl_gap > 0) begin
        mdl_gap <= mdl_gap - 1;
      end else begin
        mdl_owner <= rr_pick(mdl_ptr, req_valid);
        mdl_stall <= 0;
      end
    end
  end

  function automatic logic [15:0] model_outputs();
    logic [N-1:0] g, r;
    logic [7:0]   d;
    logic         v;
    g = '0; r = '0; d = 8'h00; v = 1'b0;
    if (mdl_owner >= 0) begin
      g = N'(1) << mdl_owner;
      r = N'(m_ready) << mdl_owner;
      d = req_data[mdl_owner*8 +: 8];
      v = req_valid[mdl_owner];
    end
    return {g, v, d, r, mdl_dc, (mdl_owner >= 0) || (mdl_gap > 0), mdl_to};
  endfunction

  bit          mon_en = 1'b0;
  logic [15:0] mon_got, mon_exp;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!rst_n) begin
        if (req_ready !== '0 || m_valid !== 1'b0) begin
          errors++;
          $display("FAIL mon_reset_cycle req_ready=%b m_valid=%b required 0/0", req_ready, m_valid);
        end
      end else begin
        mon_got = {grant, m_valid, m_data, req_ready, spi_dc, busy, timeout};
        mon_exp = model_outputs();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL mon_model t=%0t {grant,mv,md,rdy,dc,busy,to} got=%h required=%h", $time, mon_got, mon_exp);
        end
      end
    end
  end

  // ---------------- requester sources and spi_master model ----------------
  logic [9:0] src_q [N][$];       // {last, dc, data}
  bit   [N-1:0] acc;
  bit   acc_m;
  bit   [N-1:0] pause;
  bit   rand_bubble;
  int   ready_mode;               // 0 always ready, 1 spi byte timing, 2 random
  int   spi_cnt;
  bit   rst_next;

  task automatic step();
    @(posedge clk); #1;
    rst_n = rst_next;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (!(req_valid[i] && !acc[i]))
        req_valid[i] = (src_q[i].size() > 0) && !pause[i] && (!rand_bubble || $urandom_range(3) != 0);
      if (src_q[i].size() > 0) begin
        {req_last[i], req_dc[i], req_data[i*8 +: 8]} = src_q[i][0];
      end else begin
        req_valid[i] = 1'b0; req_last[i] = 1'b0; req_dc[i] = 1'b0; req_data[i*8 +: 8] = 8'h00;
      end
    end
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin
        if (acc_m) spi_cnt = 8;
        if (spi_cnt > 0) begin m_ready = 1'b0; spi_cnt--; end
        else m_ready = 1'b1;
      end
      default: m_ready = 1'($urandom_range(1));
    endcase
    @(negedge clk);
    for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
    acc_m = m_valid && m_ready;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    pause = '0; rand_bubble = 1'b0; ready_mode = 0; spi_cnt = 0;
    rst_next = 1'b0; step();
    rst_next = 1'b1; step();
  endtask

  task automatic push_frame(int r, int len);
    for (int b = 0; b < len; b++)
      src_q[r].push_back({(b == len - 1), 1'($urandom_range(1)), 8'($urandom_range(255))});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_next = 1'b0;
    step(); step();
    checks++;
    if ({grant, m_valid, m_data, req_ready, spi_dc, busy, timeout} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0000",
               {grant, m_valid, m_data, req_ready, spi_dc, busy, timeout});
    end
    rst_next = 1'b1; step();
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle grant=%b busy=%b required 00/0", grant, busy);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [9:0] exp_b [3];
    logic [9:0] e;
    int n = 0, cyc = 0;
    bit do_dc, dc_exp, done;
    exp_b = '{10'h0A0, 10'h1A1, 10'h3A2};
    clear_all(); ready_mode = 1;
    for (int k = 0; k < 3; k++) src_q[0].push_back(exp_b[k]);
    step();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_pre_grant got=%b required=00", grant); end
    step();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b required=01", grant); end
    done = 1'b0;
    while (!done && cyc < 200) begin
      do_dc = 1'b0;
      if (acc_m && n < 3) begin
        e = exp_b[n]; checks++;
        if (m_data !== e[7:0]) begin
          errors++; $display("FAIL single_data[%0d] got=%h required=%h", n, m_data, e[7:0]);
        end
        dc_exp = e[8]; do_dc = 1'b1; n++;
      end
      done = (n == 3) && do_dc;
      step(); cyc++;
      if (do_dc) begin
        checks++;
        if (spi_dc !== dc_exp) begin errors++; $display("FAIL single_dc got=%b required=%b", spi_dc, dc_exp); end
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL single_bytes got=%0d required=3", n); end
    for (int k = 0; k <= GAP; k++) begin
      if (k > 0) step();
      checks++;
      if (busy !== (k < GAP) || grant !== 2'b00) begin
        errors++; $display("FAIL single_gap[%0d] busy=%b grant=%b required busy=%b grant=00", k, busy, grant, (k < GAP));
      end
    end
  endtask

  task automatic test_contention();
    int order[$];
    int exp_ord[4];
    int zr = 0, cyc = 0;
    bit seen = 1'b0;
    logic [N-1:0] prev = '0;
    exp_ord = '{0, 1, 0, 1};
    clear_all();
    for (int f = 0; f < 2; f++) begin push_frame(0, 2); push_frame(1, 2); end
    while (order.size() < 4 && cyc < 300) begin
      step(); cyc++;
      if (grant === 2'b00) zr++;
      else begin
        if (prev === 2'b00) begin
          if (seen) begin
            checks++;
            if (zr != GAP + 1) begin errors++; $display("FAIL contention_gap got=%0d required=%0d", zr, GAP + 1); end
          end
          seen = 1'b1;
          order.push_back(grant === 2'b10 ? 1 : 0);
        end
        zr = 0;
      end
      prev = grant;
    end
    checks++;
    if (order.size() != 4) begin errors++; $display("FAIL contention_count got=%0d required=4", order.size()); end
    for (int k = 0; k < order.size() && k < 4; k++) begin
      checks++;
      if (order[k] != exp_ord[k]) begin errors++; $display("FAIL contention_order[%0d] got=%0d required=%0d", k, order[k], exp_ord[k]); end
    end
  endtask

  task automatic test_no_preempt();
    int cyc = 0;
    clear_all();
    src_q[0].push_back(10'h011); src_q[0].push_back(10'h012); src_q[0].push_back(10'h213);
    src_q[1].push_back(10'h2EE);
    while (!acc[0] && cyc < 20) begin step(); cyc++; end
    pause[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (grant !== 2'b01 || req_ready[1] !== 1'b0 || m_valid !== 1'b0) begin
        errors++; $display("FAIL nopreempt[%0d] grant=%b ready1=%b mv=%b required 01/0/0", k, grant, req_ready[1], m_valid);
      end
    end
    pause[0] = 1'b0; cyc = 0;
    while (grant !== 2'b10 && cyc < 50) begin step(); cyc++; end
    checks++;
    if (grant !== 2'b10 || src_q[0].size() != 0) begin
      errors++; $display("FAIL nopreempt_handover grant=%b r0_left=%0d required 10/0", grant, src_q[0].size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    clear_all();
    src_q[0].push_back(10'h211);
    src_q[1].push_back(10'h121); src_q[1].push_back(10'h122); src_q[1].push_back(10'h323);
    while (!acc[1] && cyc < 40) begin step(); cyc++; end
    src_q[0].push_back(10'h212);
    rst_next = 1'b0; step();
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rstmid_no_accept got=%b required=00", req_ready); end
    rst_next = 1'b1; step();
    checks++;
    if ({grant, m_valid, spi_dc, busy} !== 5'b0) begin
      errors++; $display("FAIL rstmid_state grant=%b mv=%b dc=%b busy=%b required all 0", grant, m_valid, spi_dc, busy);
    end
    step();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rstmid_rrptr got=%b required=01", grant); end
  endtask

  task automatic test_gap0();
    @(posedge clk); #1;
    z_req_valid = 2'b11; z_req_data = {8'hAA, 8'h55}; z_req_last = 2'b11; z_req_dc = 2'b10; z_m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (z_grant !== 2'b00) begin errors++; $display("FAIL gap0_pre got=%b required=00", z_grant); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (z_grant !== 2'b01 || z_m_data !== 8'h55 || z_req_ready !== 2'b01) begin
      errors++; $display("FAIL gap0_req0 grant=%b data=%h ready=%b required 01/55/01", z_grant, z_m_data, z_req_ready);
    end
    @(posedge clk); #1;
    z_req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (z_grant !== 2'b00 || z_busy !== 1'b0) begin
      errors++; $display("FAIL gap0_idle grant=%b busy=%b required 00/0", z_grant, z_busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (z_grant !== 2'b10 || z_m_data !== 8'hAA) begin
      errors++; $display("FAIL gap0_req1 grant=%b data=%h required 10/aa", z_grant, z_m_data);
    end
    @(posedge clk); #1;
    z_req_valid = 2'b00;
  endtask

  task automatic test_random();
    int pushed[N];
    int got[N];
    int cyc = 0;
    clear_all(); ready_mode = 2; rand_bubble = 1'b1;
    for (int i = 0; i < N; i++) begin
      pushed[i] = 0; got[i] = 0;
      for (int f = 0; f < 6; f++) begin
        int len = $urandom_range(4, 1);
        push_frame(i, len); pushed[i] += len;
      end
    end
    while (cyc < 4000 && (src_q[0].size() != 0 || src_q[1].size() != 0 || busy !== 1'b0)) begin
      step(); cyc++;
      for (int i = 0; i < N; i++) if (acc[i]) got[i]++;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (got[i] != pushed[i]) begin errors++; $display("FAIL random_bytes[%0d] got=%0d required=%0d", i, got[i], pushed[i]); end
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    clear_all();
    src_q[0].push_back(10'h077);
    src_q[1].push_back(10'h288);
    while (!acc[0] && cyc < 20) begin step(); cyc++; end
    step();
`ifdef SPI_ARB_TIMEOUT_EN
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 40) begin step(); cyc++; end
    checks++;
    if (cyc != TO || grant !== 2'b00) begin
      errors++; $display("FAIL timeout_pulse cycles=%0d grant=%b required %0d/00", cyc, grant, TO);
    end
    cyc = 0;
    while (grant !== 2'b10 && cyc < 20) begin step(); cyc++; end
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL timeout_next got=%b required=10", grant); end
`else
    for (int k = 0; k < 120; k++) begin
      step();
      checks++;
      if (grant !== 2'b01 || timeout !== 1'b0) begin
        errors++; $display("FAIL hold_grant[%0d] grant=%b timeout=%b required 01/0", k, grant, timeout);
      end
    end
`endif
    clear_all();
  endtask

  initial begin
    rst_n = 1'b0; rst_next = 1'b0;
    req_data = '0; req_valid = '0; req_last = '0; req_dc = '0; m_ready = 1'b1;
    z_req_data = '0; z_req_valid = '0; z_req_last = '0; z_req_dc = '0; z_m_ready = 1'b1;
    acc = '0; acc_m = 1'b0; pause = '0; rand_bubble = 1'b0; ready_mode = 0; spi_cnt = 0;
    test_reset();
    test_single();
    test_contention();
    test_no_preempt();
    test_reset_mid();
    test_gap0();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
